// File: rtl/tt_response_checker.sv
// Response checker for truth-table sweeps of small combinational cells.
// Compares each sampled DUT output against a latched truth table and reports coverage and errors.
module tt_response_checker #(
  parameter int N_IN    = 2,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [2**N_IN-1:0]   exp_tt_i,
  input  logic                 in_valid_i,
  input  logic [N_IN-1:0]      in_vec_i,
  input  logic                 out_bit_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timed_out_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [CNT_W-1:0]     sample_cnt_o,
  output logic [2**N_IN-1:0]   cov_mask_o,
  output logic                 first_fail_vld_o,
  output logic [N_IN-1:0]      first_fail_vec_o
);

  localparam int NVec = 2 ** N_IN;
  localparam int CycW = $clog2(TIMEOUT + 1);
  localparam logic [CycW-1:0]  CycLast = CycW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q;
  logic [NVec-1:0]   ttLatch_q;
  logic [CycW-1:0]   cycleCnt_q;
  logic [CNT_W-1:0]  errCnt_q, errCnt_d;
  logic [CNT_W-1:0]  sampleCnt_q, sampleCnt_d;
  logic [NVec-1:0]   covMask_q, covMask_d;
  logic              firstFailVld_q;
  logic [N_IN-1:0]   firstFailVec_q;
  logic              pass_q;
  logic              timedOut_q;
  logic              mismatch;

  // Effect of this cycle's sample, used by RUN so completion sees the sample at the same edge.
  always_comb begin
    mismatch    = in_valid_i && (out_bit_i != ttLatch_q[in_vec_i]);
    covMask_d   = covMask_q;
    if (in_valid_i) covMask_d[in_vec_i] = 1'b1;
    sampleCnt_d = (in_valid_i && sampleCnt_q != CntMax) ? sampleCnt_q + CNT_W'(1) : sampleCnt_q;
    errCnt_d    = (mismatch && errCnt_q != CntMax) ? errCnt_q + CNT_W'(1) : errCnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      ttLatch_q      <= '0;
      cycleCnt_q     <= '0;
      errCnt_q       <= '0;
      sampleCnt_q    <= '0;
      covMask_q      <= '0;
      firstFailVld_q <= 1'b0;
      firstFailVec_q <= '0;
      pass_q         <= 1'b0;
      timedOut_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q        <= RUN;
            ttLatch_q      <= exp_tt_i;
            cycleCnt_q     <= '0;
            errCnt_q       <= '0;
            sampleCnt_q    <= '0;
            covMask_q      <= '0;
            firstFailVld_q <= 1'b0;
            firstFailVec_q <= '0;
            pass_q         <= 1'b0;
            timedOut_q     <= 1'b0;
          end
        end
        RUN: begin
          errCnt_q    <= errCnt_d;
          sampleCnt_q <= sampleCnt_d;
          covMask_q   <= covMask_d;
          if (mismatch && !firstFailVld_q) begin
            firstFailVld_q <= 1'b1;
            firstFailVec_q <= in_vec_i;
          end
          if (cycleCnt_q != CycLast) cycleCnt_q <= cycleCnt_q + CycW'(1);
          // Full coverage takes priority over a timeout landing on the same edge.
          if (&covMask_d) begin
            state_q    <= DONE;
            pass_q     <= (errCnt_d == '0);
            timedOut_q <= 1'b0;
          end else if (cycleCnt_q == CycLast) begin
            state_q    <= DONE;
            pass_q     <= 1'b0;
            timedOut_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o           = (state_q == RUN);
  assign done_o           = (state_q == DONE);
  assign pass_o           = pass_q;
  assign timed_out_o      = timedOut_q;
  assign err_cnt_o        = errCnt_q;
  assign sample_cnt_o     = sampleCnt_q;
  assign cov_mask_o       = covMask_q;
  assign first_fail_vld_o = firstFailVld_q;
  assign first_fail_vec_o = firstFailVec_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: table-driven sweeps plus timeout, reset and saturation sequences.
// Expected results are queued as stimulus is driven and popped after each clock edge.
module tb_tt_response_checker;

  logic       clk = 1'b0;
  logic       rst, start, inValid, outBit;
  logic [3:0] expTt;
  logic [1:0] inVec;

  logic       busy, done, pass, timedOut, ffVld;
  logic [7:0] errCnt, sampleCnt;
  logic [3:0] covMask;
  logic [1:0] ffVec;

  logic       busy2, done2, pass2, timedOut2, ffVld2;
  logic [1:0] errCnt2, sampleCnt2;
  logic [3:0] covMask2;
  logic [1:0] ffVec2;

  int errCount   = 0;
  int checkCount = 0;

  typedef struct {
    logic       rst, st;
    logic [3:0] tt;
    logic       vld;
    logic [1:0] vec;
    logic       ob;
    logic       busy, done, pass, tmo;
    logic [7:0] err, smp;
    logic [3:0] cov;
    logic       ffv;
    logic [1:0] ffvec;
  } row_t;

  row_t tbl[$];
  row_t expQ[$];

  always #5 clk = ~clk;

  tt_response_checker #(.N_IN(2), .CNT_W(8), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .exp_tt_i(expTt),
    .in_valid_i(inValid), .in_vec_i(inVec), .out_bit_i(outBit),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timed_out_o(timedOut),
    .err_cnt_o(errCnt), .sample_cnt_o(sampleCnt), .cov_mask_o(covMask),
    .first_fail_vld_o(ffVld), .first_fail_vec_o(ffVec)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  tt_response_checker #(.N_IN(2), .CNT_W(2), .TIMEOUT(64)) dutSat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .exp_tt_i(expTt),
    .in_valid_i(inValid), .in_vec_i(inVec), .out_bit_i(outBit),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .timed_out_o(timedOut2),
    .err_cnt_o(errCnt2), .sample_cnt_o(sampleCnt2), .cov_mask_o(covMask2),
    .first_fail_vld_o(ffVld2), .first_fail_vec_o(ffVec2)
  );

  function automatic row_t mkRow(input logic r, input logic s, input logic [3:0] t,
                                 input logic v, input logic [1:0] vc, input logic o,
                                 input logic b, input logic d, input logic p, input logic to,
                                 input logic [7:0] e, input logic [7:0] sm, input logic [3:0] c,
                                 input logic fv, input logic [1:0] fvec);
    row_t x;
    x.rst = r; x.st = s; x.tt = t; x.vld = v; x.vec = vc; x.ob = o;
    x.busy = b; x.done = d; x.pass = p; x.tmo = to;
    x.err = e; x.smp = sm; x.cov = c; x.ffv = fv; x.ffvec = fvec;
    return x;
  endfunction

  task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    row_t e;
    if (expQ.size() == 0) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL %s: scoreboard empty got 0 entries expected 1", tag);
      return;
    end
    e = expQ.pop_front();
    checkField({tag, ".busy"},   {7'b0, busy},     {7'b0, e.busy});
    checkField({tag, ".done"},   {7'b0, done},     {7'b0, e.done});
    checkField({tag, ".pass"},   {7'b0, pass},     {7'b0, e.pass});
    checkField({tag, ".tmo"},    {7'b0, timedOut}, {7'b0, e.tmo});
    checkField({tag, ".err"},    errCnt,           e.err);
    checkField({tag, ".smp"},    sampleCnt,        e.smp);
    checkField({tag, ".cov"},    {4'b0, covMask},  {4'b0, e.cov});
    checkField({tag, ".ffv"},    {7'b0, ffVld},    {7'b0, e.ffv});
    checkField({tag, ".ffvec"},  {6'b0, ffVec},    {6'b0, e.ffvec});
  endtask

  task automatic applyStimulus(input row_t r, input string tag);
    @(negedge clk);
    rst = r.rst; start = r.st; expTt = r.tt;
    inValid = r.vld; inVec = r.vec; outBit = r.ob;
    expQ.push_back(r);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; expTt = 4'b0; inValid = 1'b0; inVec = 2'b0; outBit = 1'b0;

    // Reset state
    tbl.push_back(mkRow(1,0,4'b0000,0,0,0, 0,0,0,0, 0,0,4'h0,0,0));
    tbl.push_back(mkRow(1,0,4'b0000,1,3,1, 0,0,0,0, 0,0,4'h0,0,0));
    // AND reference, correct DUT; exp_tt driven to 0 after start must not matter
    tbl.push_back(mkRow(0,1,4'b1000,0,0,0, 1,0,0,0, 0,0,4'h0,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,0,0, 1,0,0,0, 0,1,4'h1,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,1,0, 1,0,0,0, 0,2,4'h3,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,2,0, 1,0,0,0, 0,3,4'h7,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,3,1, 0,1,1,0, 0,4,4'hF,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,0,1, 0,1,1,0, 0,4,4'hF,0,0));
    // Faulty DUT: vec1 and vec2 answer 1
    tbl.push_back(mkRow(0,1,4'b1000,0,0,0, 1,0,0,0, 0,0,4'h0,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,0,0, 1,0,0,0, 0,1,4'h1,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,1,1, 1,0,0,0, 1,2,4'h3,1,1));
    tbl.push_back(mkRow(0,0,4'b0000,1,2,1, 1,0,0,0, 2,3,4'h7,1,1));
    tbl.push_back(mkRow(0,0,4'b0000,1,3,1, 0,1,0,0, 2,4,4'hF,1,1));
    // Gaps and repeats, with an ignored start mid-run
    tbl.push_back(mkRow(0,1,4'b1000,0,0,0, 1,0,0,0, 0,0,4'h0,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,0,0, 1,0,0,0, 0,1,4'h1,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,0,3,1, 1,0,0,0, 0,1,4'h1,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,0,0, 1,0,0,0, 0,2,4'h1,0,0));
    tbl.push_back(mkRow(0,1,4'b0110,0,0,0, 1,0,0,0, 0,2,4'h1,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,1,0, 1,0,0,0, 0,3,4'h3,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,0,0,0, 1,0,0,0, 0,3,4'h3,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,2,0, 1,0,0,0, 0,4,4'h7,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,0,0,0, 1,0,0,0, 0,4,4'h7,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,3,1, 0,1,1,0, 0,5,4'hF,0,0));
    // Restart from DONE with an XOR table
    tbl.push_back(mkRow(0,1,4'b0110,0,0,0, 1,0,0,0, 0,0,4'h0,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,0,0, 1,0,0,0, 0,1,4'h1,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,1,1, 1,0,0,0, 0,2,4'h3,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,2,1, 1,0,0,0, 0,3,4'h7,0,0));
    tbl.push_back(mkRow(0,0,4'b0000,1,3,0, 0,1,1,0, 0,4,4'hF,0,0));

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], $sformatf("tbl%0d", i));

    // Incomplete sweep: timeout on the 64th RUN edge, sample on that edge still counted
    applyStimulus(mkRow(0,1,4'b1000,0,0,0, 1,0,0,0, 0,0,4'h0,0,0), "to_start");
    applyStimulus(mkRow(0,0,4'b0000,1,0,0, 1,0,0,0, 0,1,4'h1,0,0), "to_s0");
    applyStimulus(mkRow(0,0,4'b0000,1,1,0, 1,0,0,0, 0,2,4'h3,0,0), "to_s1");
    applyStimulus(mkRow(0,0,4'b0000,1,2,0, 1,0,0,0, 0,3,4'h7,0,0), "to_s2");
    for (int k = 4; k <= 63; k++)
      applyStimulus(mkRow(0,0,4'b0000,0,0,0, 1,0,0,0, 0,3,4'h7,0,0), $sformatf("to_wait%0d", k));
    applyStimulus(mkRow(0,0,4'b0000,1,0,0, 0,1,0,1, 0,4,4'h7,0,0), "to_end");

    // Coverage completing on the timeout edge wins
    applyStimulus(mkRow(0,1,4'b1000,0,0,0, 1,0,0,0, 0,0,4'h0,0,0), "tie_start");
    applyStimulus(mkRow(0,0,4'b0000,1,0,0, 1,0,0,0, 0,1,4'h1,0,0), "tie_s0");
    applyStimulus(mkRow(0,0,4'b0000,1,1,0, 1,0,0,0, 0,2,4'h3,0,0), "tie_s1");
    applyStimulus(mkRow(0,0,4'b0000,1,2,0, 1,0,0,0, 0,3,4'h7,0,0), "tie_s2");
    for (int k = 4; k <= 63; k++)
      applyStimulus(mkRow(0,0,4'b0000,0,0,0, 1,0,0,0, 0,3,4'h7,0,0), $sformatf("tie_wait%0d", k));
    applyStimulus(mkRow(0,0,4'b0000,1,3,1, 0,1,1,0, 0,4,4'hF,0,0), "tie_end");

    // Reset mid-run discards everything; in_valid in IDLE is ignored
    applyStimulus(mkRow(0,1,4'b1000,0,0,0, 1,0,0,0, 0,0,4'h0,0,0), "rst_start");
    applyStimulus(mkRow(0,0,4'b0000,1,0,1, 1,0,0,0, 1,1,4'h1,1,0), "rst_s0");
    applyStimulus(mkRow(0,0,4'b0000,1,1,0, 1,0,0,0, 1,2,4'h3,1,0), "rst_s1");
    applyStimulus(mkRow(1,0,4'b0000,0,0,0, 0,0,0,0, 0,0,4'h0,0,0), "rst_hit");
    applyStimulus(mkRow(0,0,4'b0000,1,2,1, 0,0,0,0, 0,0,4'h0,0,0), "rst_idle");

    // Saturation: five mismatches on vec0
    applyStimulus(mkRow(0,1,4'b1000,0,0,0, 1,0,0,0, 0,0,4'h0,0,0), "sat_start");
    for (int k = 1; k <= 5; k++)
      applyStimulus(mkRow(0,0,4'b0000,1,0,1, 1,0,0,0, 8'(k),8'(k),4'h1,1,0), $sformatf("sat_s%0d", k));
    checkField("sat_err2", {6'b0, errCnt2},    8'd3);
    checkField("sat_smp2", {6'b0, sampleCnt2}, 8'd3);
    checkField("sat_busy2", {7'b0, busy2},     8'd1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
